cam_cfg_sequencer: RTL and testbench
====================================

Name: cam_cfg_sequencer

Overview:
- Boot-time register loader for the camera. It walks a table of {sub_addr, data} write entries and issues each entry as one I2C write transaction through the camera I2C driver's ena/busy handshake.
- Supports inline millisecond delays, an end marker, ack-error retry and a busy-rise timeout.
- Sits between the top-level reset/start logic and the I2C driver. The table lives in an external ROM read through a 1-cycle-latency port.

Parameters:
- CLK_FREQ, 50000000, clk frequency in Hz; sets the 1 ms tick prescaler.
- DEV_ADDR, 8'h42, 8-bit camera device write address driven on i2c_addr.
- TBL_AW, 8, table address width (up to 256 entries).
- MAX_RETRY, 3, retries per entry after an ack_err or timeout before ERROR.
- BUSY_TIMEOUT, 200000, clk cycles to wait for i2c_busy to rise after ena.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  1-cycle pulse; begins the sequence from table entry 0
- tbl_addr  out  TBL_AW  ROM read address
- tbl_data  in  16  ROM data {sub_addr[15:8], data[7:0]}; valid 1 cycle after tbl_addr
- i2c_ena  out  1  transaction request to the I2C driver
- i2c_addr  out  8  constant DEV_ADDR
- i2c_rw  out  1  constant 0 (write)
- i2c_sub_addr  out  8  register address of the current entry
- i2c_data_wr  out  8  register data of the current entry
- i2c_busy  in  1  driver busy; asynchronous to clk edges, so it is synchronised
- i2c_ack_err  in  1  driver sticky ack error; synchronised
- busy  out  1  sequence in progress
- done  out  1  sticky; table completed without error
- error  out  1  sticky; retries exhausted
- err_index  out  TBL_AW  entry index at the point of failure

Behaviour:
- Reset (rst_n=0 at posedge clk) sets:
  - state=IDLE
  - all outputs 0, except i2c_addr=DEV_ADDR
  - index and retry counter 0, prescaler 0
- i2c_busy and i2c_ack_err each pass through a 2-flop synchroniser. All decisions below use the synchronised values (busy_s, err_s).
- Table encoding:
  - sub_addr 8'hFF with data 8'hFF: END.
  - sub_addr 8'hFF with any other data: DELAY of data ms (0 = no delay, advance immediately).
  - Anything else: WRITE.
- States:
  - IDLE: busy=0. A start pulse clears done, error and err_index, sets index=0, then goes to FETCH. A start arriving in any other state is ignored.
  - FETCH: drive tbl_addr=index, 1 cycle, then LATCH.
  - LATCH: capture tbl_data into sub/data registers, decode, then dispatch:
    - END → DONE
    - DELAY → DELAY
    - WRITE → WAIT_IDLE
  - WAIT_IDLE: wait for busy_s=0. The driver comes out of its reset with busy=1, so this wait also covers the driver's post-reset state. Then go to REQ.
  - REQ: i2c_ena=1; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: hold i2c_ena=1.
    - On busy_s=1: i2c_ena=0 the same cycle, go to WAIT_DONE.
    - When the timeout counter reaches BUSY_TIMEOUT-1: i2c_ena=0, go to RETRY.
  - WAIT_DONE: wait for busy_s=0, then go to CHECK.
  - CHECK:
    - err_s=0: retry counter=0, index+1, go to FETCH.
    - err_s=1: go to RETRY.
  - RETRY:
    - retry counter < MAX_RETRY: increment it, go to WAIT_IDLE (same entry).
    - otherwise: error=1, err_index=index, go to ERROR.
  - DELAY: 1 ms prescaler (CLK_FREQ/1000 cycles per tick) decrements the ms count. On reaching 0, index+1 and go to FETCH.
  - DONE: done=1, busy=0, go to IDLE.
  - ERROR: busy=0, go to IDLE with error held.
- busy=1 in every state except IDLE, DONE and ERROR.
- i2c_sub_addr and i2c_data_wr are stable from LATCH until the next LATCH.
- Index wrap: if index reaches 2^TBL_AW-1 and that entry is not END, the sequence terminates as if END had been read: done=1.
- The driver's ack_err is cleared by the driver in its own start phase. The sequencer samples err_s only in CHECK.
- Reset mid-transaction: return to IDLE and drop i2c_ena immediately. No stop condition is forced; the driver's own reset handles the bus.

Decomposition:
- Package cam_cfg_pkg holds:
  - state enum
  - TBL_END_SUB=8'hFF, TBL_END_DATA=8'hFF
  - ms_div function (CLK_FREQ/1000)
- One natural sub-module, cam_cfg_rom: a synchronous table ROM with 1-cycle latency, initialised from a memory file. It is instantiated beside the sequencer, not inside it.

Test Plan:
- Table {12/80, 11/01, FF/FF}, model driver acks both (busy high 40 cycles each) → two ena pulses with sub_addr 12 then 11 and data 80 then 01; done=1, error=0, busy falls.
- Table {FF/03, 3A/04, FF/FF} with CLK_FREQ=100000 → first ena appears ≥300 cycles after start; done=1.
- Model asserts ack_err on entry 1 every attempt, MAX_RETRY=3 → 4 ena pulses for entry 1; error=1, err_index=1, done=0.
- Model never raises busy, BUSY_TIMEOUT=50 → ena dropped after 50 cycles, retried; error=1 after MAX_RETRY+1 attempts.
- Driver busy held 1 for 100 cycles after reset, then start → no ena until busy_s=0.
- rst_n low during WAIT_DONE → next cycle i2c_ena=0, busy=0, done=0, error=0; a new start completes normally.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared types and helpers for the camera boot-time register loader.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT_IDLE,
    S_REQ,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CHECK,
    S_RETRY,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    E_WRITE,
    E_DELAY,
    E_END
  } entry_t;

  localparam logic [7:0] TBL_END_SUB  = 8'hFF;
  localparam logic [7:0] TBL_END_DATA = 8'hFF;

  function automatic int unsigned ms_div(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

  // sub_addr FF is reserved: FF/FF ends the table, FF/nn waits nn ms.
  function automatic entry_t entry_kind(input logic [15:0] e);
    if (e[15:8] != TBL_END_SUB) return E_WRITE;
    if (e[7:0] == TBL_END_DATA) return E_END;
    return E_DELAY;
  endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// Register table ROM, 1-cycle read latency. Contents come from TBL_INIT,
// which the build flow generates from the camera's table file.
module cam_cfg_rom
  import cam_cfg_pkg::*;
#(
  parameter int unsigned                 TBL_AW   = 8,
  parameter logic [16*(2**TBL_AW)-1:0]   TBL_INIT = {(2**TBL_AW){TBL_END_SUB, TBL_END_DATA}}
) (
  input  logic              clk,
  input  logic [TBL_AW-1:0] addr,
  output logic [15:0]       data
);

  logic [15:0] mem [2**TBL_AW];

  for (genvar i = 0; i < 2**TBL_AW; i++) begin : g_mem
    assign mem[i] = TBL_INIT[16*i +: 16];
  end

  always_ff @(posedge clk) data <= mem[addr];

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera register table and issues each entry as one I2C write
// via the driver's ena/busy handshake, with ms delays, retry and timeout.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int unsigned TBL_AW       = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned BUSY_TIMEOUT = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              i2c_ena,
  output logic [7:0]        i2c_addr,
  output logic              i2c_rw,
  output logic [7:0]        i2c_sub_addr,
  output logic [7:0]        i2c_data_wr,
  input  logic              i2c_busy,
  input  logic              i2c_ack_err,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_index
);

  localparam int unsigned MS_CYC = ms_div(CLK_FREQ);
  localparam int PW = (MS_CYC > 1)       ? $clog2(MS_CYC)        : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT)  : 1;
  localparam int RW = (MAX_RETRY > 0)    ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TBL_AW-1:0] LAST_IDX = '1;

  state_t            state;
  logic [TBL_AW-1:0] index;
  logic [RW-1:0]     retry;
  logic [PW-1:0]     pre;
  logic [TW-1:0]     tmo;
  logic [7:0]        ms_left;
  logic              busy_m, busy_s, err_m, err_s;

  assign tbl_addr = index;
  assign i2c_addr = DEV_ADDR;
  assign i2c_rw   = 1'b0;

  // Driver signals are not timed to clk. busy resets high so nothing is
  // requested before the synchroniser has seen the driver's real level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_m <= 1'b1;
      busy_s <= 1'b1;
      err_m  <= 1'b0;
      err_s  <= 1'b0;
    end else begin
      busy_m <= i2c_busy;
      busy_s <= busy_m;
      err_m  <= i2c_ack_err;
      err_s  <= err_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      index        <= '0;
      retry        <= '0;
      pre          <= '0;
      tmo          <= '0;
      ms_left      <= '0;
      i2c_ena      <= 1'b0;
      i2c_sub_addr <= '0;
      i2c_data_wr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_index    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            index     <= '0;
            retry     <= '0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end

        S_FETCH: state <= S_LATCH;

        S_LATCH: begin
          i2c_sub_addr <= tbl_data[15:8];
          i2c_data_wr  <= tbl_data[7:0];
          // The last slot is never executed: running off the table ends it.
          if (index == LAST_IDX || entry_kind(tbl_data) == E_END) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else if (entry_kind(tbl_data) == E_DELAY) begin
            if (tbl_data[7:0] == 8'd0) begin
              index <= index + TBL_AW'(1);
              state <= S_FETCH;
            end else begin
              ms_left <= tbl_data[7:0];
              pre     <= '0;
              state   <= S_DELAY;
            end
          end else begin
            state <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: if (!busy_s) state <= S_REQ;

        S_REQ: begin
          i2c_ena <= 1'b1;
          tmo     <= '0;
          state   <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (busy_s) begin
            i2c_ena <= 1'b0;
            state   <= S_WAIT_DONE;
          end else if (tmo == TW'(BUSY_TIMEOUT - 1)) begin
            i2c_ena <= 1'b0;
            state   <= S_RETRY;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        S_WAIT_DONE: if (!busy_s) state <= S_CHECK;

        // ack_err is sticky in the driver until its next start, so it is
        // only meaningful once the transaction has fully finished.
        S_CHECK: begin
          if (err_s) begin
            state <= S_RETRY;
          end else begin
            retry <= '0;
            index <= index + TBL_AW'(1);
            state <= S_FETCH;
          end
        end

        S_RETRY: begin
          if (retry < RW'(MAX_RETRY)) begin
            retry <= retry + RW'(1);
            state <= S_WAIT_IDLE;
          end else begin
            error     <= 1'b1;
            err_index <= index;
            busy      <= 1'b0;
            state     <= S_ERROR;
          end
        end

        S_DELAY: begin
          if (pre == PW'(MS_CYC - 1)) begin
            pre     <= '0;
            ms_left <= ms_left - 8'd1;
            if (ms_left == 8'd1) begin
              index <= index + TBL_AW'(1);
              state <= S_FETCH;
            end
          end else begin
            pre <= pre + PW'(1);
          end
        end

        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: table ROM model, randomised I2C driver model
// and a table-walking reference that predicts the write stream and outcome.
module tb_cam_cfg_sequencer;

  localparam int MAX_RETRY = 3;
  localparam int TMO       = 50;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0]  tbl_addr, err_index;
  logic [15:0] tbl_data;
  logic        i2c_ena, i2c_rw, busy, done, error;
  logic [7:0]  i2c_addr, i2c_sub_addr, i2c_data_wr;
  logic        i2c_busy = 1'b0, i2c_ack_err = 1'b0;

  always #5 clk = ~clk;

  cam_cfg_sequencer #(
    .CLK_FREQ(100000), .DEV_ADDR(8'h42), .TBL_AW(4),
    .MAX_RETRY(MAX_RETRY), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_sub_addr(i2c_sub_addr), .i2c_data_wr(i2c_data_wr),
    .i2c_busy(i2c_busy), .i2c_ack_err(i2c_ack_err),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  logic [15:0] rom [16];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver model ----------------
  bit         never_busy = 0, bad_en = 0, drv_kill = 0;
  logic [7:0] bad_sub = 8'h00;
  int         blen = 40, drv_hold = 0;

  initial begin : driver
    int phase, cnt;
    bit fail_now;
    phase = 0; cnt = 0; fail_now = 0;
    forever begin
      @(posedge clk); #2;
      if (drv_kill) begin
        phase = 0; i2c_busy = 0; i2c_ack_err = 0; drv_kill = 0;
      end else if (drv_hold > 0) begin
        i2c_busy = 1; drv_hold--;
        if (drv_hold == 0) i2c_busy = 0;
      end else begin
        case (phase)
          0: if (i2c_ena && !never_busy) begin
               phase = 1; cnt = $urandom_range(3, 1);
               fail_now = bad_en && (i2c_sub_addr == bad_sub);
             end
          1: begin
               cnt--;
               if (cnt == 0) begin i2c_ack_err = 0; i2c_busy = 1; cnt = blen; phase = 2; end
             end
          2: begin
               cnt--;
               if (cnt == 0) begin i2c_busy = 0; i2c_ack_err = fail_now; phase = 3; end
             end
          default: if (!i2c_ena) phase = 0;
        endcase
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] exp_q [$];
  bit          exp_done, exp_err;
  int          exp_idx;

  task automatic build_expect();
    bit f;
    exp_q.delete(); exp_done = 0; exp_err = 0; exp_idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15 || rom[i] == 16'hFFFF) begin exp_done = 1; break; end
      if (rom[i][15:8] == 8'hFF) continue;
      f = never_busy || (bad_en && rom[i][15:8] == bad_sub);
      for (int k = 0; k < (f ? MAX_RETRY + 1 : 1); k++) exp_q.push_back(rom[i]);
      if (f) begin exp_err = 1; exp_idx = i; break; end
    end
  endtask

  // ---------------- compare process ----------------
  bit          mon_en = 0;
  int          ncyc = 0, last_busy_cyc = -100, ena_len = 0, pulses = 0, first_ena_cyc = 0;
  logic [7:0]  first_sub, first_dat, last_sub, last_dat;
  logic [15:0] cur = '0;

  initial begin : monitor
    bit prev_ena;
    prev_ena = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ncyc++;
        chk("i2c_addr", i2c_addr, 8'h42);
        chk("i2c_rw", i2c_rw, 1'b0);
        chk("done_and_error", done & error, 1'b0);
        if (i2c_ena && !prev_ena) begin
          pulses++;
          if (pulses == 1) begin
            first_sub = i2c_sub_addr; first_dat = i2c_data_wr; first_ena_cyc = ncyc;
          end
          last_sub = i2c_sub_addr; last_dat = i2c_data_wr;
          cur = {i2c_sub_addr, i2c_data_wr};
          chk("ena_busy", busy, 1'b1);
          chk("ena_after_idle", (ncyc - last_busy_cyc) >= 4, 1'b1);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ena: got %h want no request", cur);
          end else begin
            chk("ena_entry", cur, exp_q.pop_front());
          end
          ena_len = 0;
        end
        if (i2c_ena && prev_ena) chk("ena_stable", {i2c_sub_addr, i2c_data_wr}, cur);
        if (i2c_ena) ena_len++;
        if (!i2c_ena && prev_ena && never_busy) chk("ena_timeout_len", ena_len, TMO);
        if (i2c_busy) last_busy_cyc = ncyc;
        prev_ena = i2c_ena;
      end
    end
  end

  // ---------------- sequences ----------------
  int st_cyc;

  task automatic run_seq(input string tag, input bit restart_mid);
    int n;
    build_expect();
    pulses = 0;
    @(negedge clk); start = 1; st_cyc = ncyc;
    @(negedge clk); start = 0;
    n = 0;
    while (!(done || error) && n < 20000) begin
      @(negedge clk); n++;
      if (restart_mid && n == 5) begin
        start = 1; @(negedge clk); start = 0; n++;
      end
    end
    if (n >= 20000) begin
      total++; bad++;
      $display("FAIL %s_finish: got no done/error want done or error", tag);
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_err_index"}, err_index, exp_idx);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ena"}, i2c_ena, 1'b0);
    chk({tag, "_missing"}, exp_q.size(), 0);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin : stim
    int n, len;
    load_t1();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mon_en = 1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_ena", i2c_ena, 1'b0);
    chk("rst_err_index", err_index, 4'd0);
    chk("rst_tbl_addr", tbl_addr, 4'd0);
    chk("rst_sub", i2c_sub_addr, 8'h00);
    chk("rst_data", i2c_data_wr, 8'h00);

    // two plain writes
    blen = 40; run_seq("t1", 0);
    chk("t1_pulses", pulses, 2);
    chk("t1_first", {first_sub, first_dat}, 16'h1280);
    chk("t1_last", {last_sub, last_dat}, 16'h1101);

    // 3 ms delay before the first write (100 cycles per ms here)
    rom[0] = 16'hFF03; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
    run_seq("t2", 0);
    chk("t2_delay_window", (first_ena_cyc - st_cyc) >= 300 && (first_ena_cyc - st_cyc) <= 320, 1'b1);
    chk("t2_pulses", pulses, 1);

    // entry 1 always nacks
    load_t1(); bad_en = 1; bad_sub = 8'h11;
    run_seq("t3", 0);
    chk("t3_pulses", pulses, 5);
    chk("t3_err_index", err_index, 4'd1);
    chk("t3_error", error, 1'b1);
    bad_en = 0;

    // driver never answers
    rom[0] = 16'h3344; rom[1] = 16'hFFFF; never_busy = 1;
    run_seq("t4", 0);
    chk("t4_pulses", pulses, 4);
    chk("t4_error", error, 1'b1);
    never_busy = 0;

    // driver busy for 100 cycles out of its own reset
    load_t1();
    rst_n = 0; drv_kill = 1; drv_hold = 100;
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_seq("t5", 0);
    chk("t5_no_early_ena", (first_ena_cyc - st_cyc) >= 95, 1'b1);
    chk("t5_pulses", pulses, 2);

    // reset while a transaction is in flight
    build_expect(); pulses = 0;
    @(negedge clk); start = 1; @(negedge clk); start = 0;
    n = 0;
    while (!i2c_busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL t6_busy_rise: got no driver busy want busy");
    end
    repeat (6) @(negedge clk);
    rst_n = 0; drv_kill = 1;
    @(negedge clk);
    chk("t6_rst_ena", i2c_ena, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_error", error, 1'b0);
    rst_n = 1;
    @(negedge clk);
    run_seq("t6", 0);

    // table with no END: last slot terminates the walk
    for (int i = 0; i < 16; i++) rom[i] = {8'(i + 1), 8'(i * 3)};
    blen = 8; run_seq("t7", 0);
    chk("t7_pulses", pulses, 15);

    // randomised tables, with an ignored start mid-run
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
      len = $urandom_range(8, 3);
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(3, 0) == 0) rom[i] = {8'hFF, 8'($urandom_range(1, 0))};
        else rom[i] = {8'($urandom_range(254, 0)), 8'($urandom)};
      end
      bad_en  = 1'($urandom_range(1, 0));
      bad_sub = rom[$urandom_range(len - 1, 0)][15:8];
      blen    = $urandom_range(30, 5);
      run_seq("rnd", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
